// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS branch predictor slice.
//   ADDR_W_DEF  default word-address width (matches ICACHE_addr)
//   ctr_wnt/ctr_wt/ctr_max  prediction-counter encodings for a given width
package mips_pkg;

    localparam int ADDR_W_DEF = 30;

    // Weakly not-taken: just below the taken threshold (MSB clear).
    function automatic int ctr_wnt(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Weakly taken: lowest value with the MSB set.
    function automatic int ctr_wt(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int ctr_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/mips_branch_predictor_if.sv
// Lookup and training bus between the pipeline and the branch predictor.
//   if_pc / pred_taken / pred_target       IF-stage lookup
//   upd_valid / upd_pc / upd_taken /
//   upd_target / upd_mispredict            ID/EX resolution (training)
// master: pipeline side; slave: predictor side.
interface mips_branch_predictor_if #(
    parameter int ADDR_W = mips_pkg::ADDR_W_DEF
);
    logic [ADDR_W-1:0] if_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_mispredict;

    modport master (
        output if_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  pred_taken, pred_target
    );

    modport slave (
        input  if_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
        output pred_taken, pred_target
    );
endinterface

// File: rtl/mips_sat_counter.sv
// Combinational saturating up/down next-value function.
//   cur  current value
//   inc  1: increment (stick at all-ones), 0: decrement (stick at zero)
//   nxt  next value
module mips_sat_counter #(
    parameter int W = 2
) (
    input  logic [W-1:0] cur,
    input  logic         inc,
    output logic [W-1:0] nxt
);
    always_comb begin
        nxt = cur;
        if (inc) begin
            if (cur != '1) nxt = cur + 1'b1;
        end else begin
            if (cur != '0) nxt = cur - 1'b1;
        end
    end
endmodule

// File: rtl/mips_branch_predictor.sv
// Direct-mapped BTB with per-entry saturating prediction counter, plus
// saturating branch / mispredict performance counters.
//   clk, rst_n        clock, asynchronous active-low reset
//   stall             pipeline stall; blocks training and perf counting
//   flush             invalidate every BTB entry at the next edge
//   bp (slave)        IF lookup (combinational) and ID/EX training bus
//   perf_branches     committed updates
//   perf_mispredicts  committed mispredicts
// Storage is flat registers so a flush clears all valid bits in one cycle.
module mips_branch_predictor
    import mips_pkg::*;
#(
    parameter int ENTRIES = 32,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    flush,
    mips_branch_predictor_if.slave  bp,
    output logic [PERF_W-1:0]       perf_branches,
    output logic [PERF_W-1:0]       perf_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W;

    localparam logic [CNT_W-1:0] WNT = CNT_W'(ctr_wnt(CNT_W));
    localparam logic [CNT_W-1:0] WT  = CNT_W'(ctr_wt(CNT_W));

    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][ADDR_W-1:0] target_q;
    logic [ENTRIES-1:0][CNT_W-1:0]  ctr_q;

    logic [PERF_W-1:0] br_q, mp_q, br_nxt, mp_nxt;

    // ---------------- lookup ----------------
    logic [IDX_W-1:0] idx_l;
    logic [TAG_W-1:0] tag_l;
    logic             hit_l;

    assign idx_l = bp.if_pc[IDX_W-1:0];
    assign tag_l = bp.if_pc[ADDR_W-1:IDX_W];
    assign hit_l = valid_q[idx_l] && (tag_q[idx_l] == tag_l);

    assign bp.pred_taken  = hit_l && ctr_q[idx_l][CNT_W-1];
    assign bp.pred_target = bp.pred_taken ? target_q[idx_l]
                                          : bp.if_pc + ADDR_W'(1);

    // ---------------- training ----------------
    logic [IDX_W-1:0] idx_u;
    logic [TAG_W-1:0] tag_u;
    logic             hit_u;
    logic             commit;
    logic [CNT_W-1:0] ctr_nxt;

    assign idx_u  = bp.upd_pc[IDX_W-1:0];
    assign tag_u  = bp.upd_pc[ADDR_W-1:IDX_W];
    assign hit_u  = valid_q[idx_u] && (tag_q[idx_u] == tag_u);
    assign commit = bp.upd_valid && !stall && !flush;

    mips_sat_counter #(.W(CNT_W)) u_ctr_next (
        .cur (ctr_q[idx_u]),
        .inc (bp.upd_taken),
        .nxt (ctr_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            tag_q    <= '0;
            target_q <= '0;
            ctr_q    <= {ENTRIES{WNT}};
        end else if (flush) begin
            // Counters and targets survive a flush; only the valid bits go.
            valid_q <= '0;
        end else if (commit) begin
            if (hit_u) begin
                ctr_q[idx_u] <= ctr_nxt;
                if (bp.upd_taken) target_q[idx_u] <= bp.upd_target;
            end else if (bp.upd_taken) begin
                valid_q[idx_u]  <= 1'b1;
                tag_q[idx_u]    <= tag_u;
                target_q[idx_u] <= bp.upd_target;
                ctr_q[idx_u]    <= WT;
            end
        end
    end

    // ---------------- performance counters ----------------
    mips_sat_counter #(.W(PERF_W)) u_br_next (
        .cur (br_q),
        .inc (1'b1),
        .nxt (br_nxt)
    );

    mips_sat_counter #(.W(PERF_W)) u_mp_next (
        .cur (mp_q),
        .inc (1'b1),
        .nxt (mp_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (commit) begin
            br_q <= br_nxt;
            if (bp.upd_mispredict) mp_q <= mp_nxt;
        end
    end

    assign perf_branches    = br_q;
    assign perf_mispredicts = mp_q;

endmodule

// File: tb/tb_mips_branch_predictor.sv
module tb_mips_branch_predictor;

    logic clk;
    logic rst_n;
    logic stall;
    logic flush;
    logic [3:0] perf_branches;
    logic [3:0] perf_mispredicts;

    mips_branch_predictor_if #(.ADDR_W(30)) bp ();

    mips_branch_predictor #(
        .ENTRIES (32),
        .ADDR_W  (30),
        .CNT_W   (2),
        .PERF_W  (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .flush            (flush),
        .bp               (bp),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int v;       // upd_valid
        int tk;      // upd_taken
        int mp;      // upd_mispredict
        int st;      // stall
        int fl;      // flush
        int upc;     // upd_pc
        int utgt;    // upd_target
        int lpc;     // if_pc after the edge
        int e_tk;    // expected pred_taken
        int e_tgt;   // expected pred_target
        int e_br;    // expected perf_branches
        int e_mp;    // expected perf_mispredicts
    } vec_t;

    vec_t vec[18];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int e_tk, input int e_tgt,
                             input int e_br, input int e_mp);
        check({tag, ".pred_taken"},  32'(bp.pred_taken),  e_tk);
        check({tag, ".pred_target"}, 32'(bp.pred_target), e_tgt);
        check({tag, ".perf_br"},     32'(perf_branches),  e_br);
        check({tag, ".perf_mp"},     32'(perf_mispredicts), e_mp);
    endtask

    task automatic clear_upd();
        bp.upd_valid      = 1'b0;
        bp.upd_taken      = 1'b0;
        bp.upd_mispredict = 1'b0;
        bp.upd_pc         = '0;
        bp.upd_target     = '0;
        stall             = 1'b0;
        flush             = 1'b0;
    endtask

    initial begin
        //        v tk mp st fl  upc   utgt  lpc   tk  tgt   br  mp
        vec[0]  = '{1, 1, 1, 0, 0, 'h10, 'h40, 'h10, 1, 'h40, 1,  1}; // allocate, ctr=WT
        vec[1]  = '{1, 0, 1, 0, 0, 'h10, 'h00, 'h10, 0, 'h11, 2,  2}; // ctr 2->1
        vec[2]  = '{1, 0, 0, 0, 0, 'h10, 'h00, 'h10, 0, 'h11, 3,  2}; // ctr 1->0
        vec[3]  = '{1, 1, 1, 0, 0, 'h10, 'h44, 'h10, 0, 'h11, 4,  3}; // ctr 0->1, tgt 0x44
        vec[4]  = '{1, 1, 0, 0, 0, 'h10, 'h40, 'h10, 1, 'h40, 5,  3}; // ctr 2, tgt 0x40
        vec[5]  = '{1, 1, 0, 0, 0, 'h10, 'h40, 'h10, 1, 'h40, 6,  3}; // ctr 3
        vec[6]  = '{1, 1, 0, 0, 0, 'h10, 'h40, 'h10, 1, 'h40, 7,  3}; // saturated
        vec[7]  = '{1, 1, 0, 0, 0, 'h10, 'h40, 'h10, 1, 'h40, 8,  3};
        vec[8]  = '{1, 1, 0, 0, 0, 'h10, 'h40, 'h10, 1, 'h40, 9,  3};
        vec[9]  = '{1, 0, 1, 0, 0, 'h10, 'h00, 'h10, 1, 'h40, 10, 4}; // 3->2 still taken
        vec[10] = '{1, 0, 0, 0, 0, 'h10, 'h00, 'h10, 0, 'h11, 11, 4}; // 2->1
        vec[11] = '{1, 1, 0, 0, 0, 'h10, 'h40, 'h30, 0, 'h31, 12, 4}; // alias lookup misses
        vec[12] = '{0, 0, 0, 0, 0, 'h00, 'h00, 'h10, 1, 'h40, 12, 4}; // 0x10 taken again
        vec[13] = '{1, 1, 1, 0, 0, 'h30, 'h80, 'h10, 0, 'h11, 13, 5}; // 0x30 replaces 0x10
        vec[14] = '{0, 0, 0, 0, 0, 'h00, 'h00, 'h30, 1, 'h80, 13, 5};
        vec[15] = '{1, 0, 0, 0, 0, 'h55, 'h99, 'h55, 0, 'h56, 14, 5}; // not-taken miss
        vec[16] = '{1, 1, 1, 0, 1, 'h30, 'h88, 'h30, 0, 'h31, 14, 5}; // flush beats commit
        vec[17] = '{1, 1, 0, 1, 0, 'h07, 'h99, 'h07, 0, 'h08, 14, 5}; // stalled, no commit

        clear_upd();
        bp.if_pc = 30'h10;
        rst_n    = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check_all("reset", 0, 'h11, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_all("post_reset", 0, 'h11, 0, 0);

        for (int i = 0; i < 18; i++) begin
            bp.upd_valid      = vec[i].v[0];
            bp.upd_taken      = vec[i].tk[0];
            bp.upd_mispredict = vec[i].mp[0];
            stall             = vec[i].st[0];
            flush             = vec[i].fl[0];
            bp.upd_pc         = 30'(vec[i].upc);
            bp.upd_target     = 30'(vec[i].utgt);
            bp.if_pc          = 30'(vec[i].lpc);
            step();
            check_all($sformatf("vec%0d", i), vec[i].e_tk, vec[i].e_tgt,
                      vec[i].e_br, vec[i].e_mp);
            clear_upd();
        end

        // Held update under a 3-cycle stall, committing on release.
        bp.upd_valid  = 1'b1;
        bp.upd_taken  = 1'b1;
        bp.upd_pc     = 30'h07;
        bp.upd_target = 30'h99;
        bp.if_pc      = 30'h07;
        stall         = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d.pred_taken", c), 32'(bp.pred_taken), 0);
            check($sformatf("stall%0d.perf_br", c), 32'(perf_branches), 14);
        end
        stall = 1'b0;
        #1;
        // Same-cycle lookup sees the table before the pending update.
        check("nobypass.pred_taken", 32'(bp.pred_taken), 0);
        check("nobypass.pred_target", 32'(bp.pred_target), 'h08);
        step();
        clear_upd();
        check_all("stall_release", 1, 'h99, 15, 5);

        // Asynchronous reset mid-cycle clears without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        check_all("async_reset", 0, 'h08, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bp.if_pc = 30'h10;
        step();
        check_all("after_reset_0x10", 0, 'h11, 0, 0);

        // Perf counters saturate at all-ones (PERF_W=4 -> 15).
        bp.upd_valid      = 1'b1;
        bp.upd_taken      = 1'b1;
        bp.upd_mispredict = 1'b1;
        bp.upd_pc         = 30'h21;
        bp.upd_target     = 30'h05;
        bp.if_pc          = 30'h21;
        for (int k = 0; k < 20; k++) step();
        clear_upd();
        check_all("perf_sat", 1, 'h05, 15, 15);
        step();
        check_all("perf_hold", 1, 'h05, 15, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
